// File: rtl/joypad_io_pkg.sv
// Joypad port responder: shared constants and types.
// Used by RTL and bench via import joypad_io_pkg::*.
package joypad_io_pkg;

  localparam logic [15:0] JOY0_ADDR_DEF = 16'h4016;
  localparam logic [15:0] JOY1_ADDR_DEF = 16'h4017;
  localparam logic [7:0]  JOY_OPEN_BUS  = 8'h40;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] joypad_btn_t;

endpackage

// File: rtl/joypad_shift.sv
// One pad: input synchronizer, parallel load, serial shift.
// Ports: clk, reset_n, strobe, shift_en, btn -> bit0.
module joypad_shift
  import joypad_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        shift_en,
  input  joypad_btn_t btn,
  output logic        bit0
);

  joypad_btn_t r_sync [SYNC_STAGES];
  joypad_btn_t r_sr;
  joypad_btn_t w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign bit0     = r_sr[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
      r_sr <= '0;
    end else begin
      r_sync[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      // Load wins over shift; 1s fill after
      // the last button has been shifted out.
      if (strobe)
        r_sr <= w_synced;
      else if (shift_en)
        r_sr <= {1'b1, r_sr[7:1]};
    end
  end

endmodule

// File: rtl/joypad_io.sv
// Controller-port responder for $4016/$4017 on the CPU bus.
// Ports: clk, reset_n, addr, din, we, re, pad0/1_btn -> dout, dout_en.
module joypad_io
  import joypad_io_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int REG_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] JOY0_ADDR = JOY0_ADDR_DEF,
  parameter logic [ADDR_WIDTH-1:0] JOY1_ADDR = JOY1_ADDR_DEF,
  parameter logic [REG_WIDTH-1:0]  OPEN_BUS  = JOY_OPEN_BUS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  din,
  input  logic                  we,
  input  logic                  re,
  input  joypad_btn_t           pad0_btn,
  input  joypad_btn_t           pad1_btn,
  output logic [REG_WIDTH-1:0]  dout,
  output logic                  dout_en
);

  logic r_strobe;
  logic w_sel0;
  logic w_sel1;
  logic w_rd;
  logic w_bit0;
  logic w_bit1;
  logic w_unused_din;

  assign w_sel0 = (addr == JOY0_ADDR);
  assign w_sel1 = (addr == JOY1_ADDR);
  // A simultaneous write suppresses the read.
  assign w_rd   = re & ~we;
  assign w_unused_din = ^din[REG_WIDTH-1:1];

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_strobe <= 1'b0;
    else if (we && w_sel0)
      r_strobe <= din[0];
  end

  joypad_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pad0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe   (r_strobe),
    .shift_en (w_rd & w_sel0),
    .btn      (pad0_btn),
    .bit0     (w_bit0)
  );

  joypad_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pad1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe   (r_strobe),
    .shift_en (w_rd & w_sel1),
    .btn      (pad1_btn),
    .bit0     (w_bit1)
  );

  always_comb begin
    dout_en = w_rd & (w_sel0 | w_sel1);
    dout    = '0;
    if (dout_en)
      dout = {OPEN_BUS[REG_WIDTH-1:1],
              w_sel0 ? w_bit0 : w_bit1};
  end

endmodule

// File: tb/tb_joypad_io.sv
// Self-checking bench for joypad_io.
// Scoreboard queue of expected {dout_en, dout}.
module tb_joypad_io;
  import joypad_io_pkg::*;

  typedef struct packed {
    logic       en;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        we;
  logic        re;
  joypad_btn_t pad0_btn;
  joypad_btn_t pad1_btn;
  logic [7:0]  dout;
  logic        dout_en;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  joypad_io dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .din      (din),
    .we       (we),
    .re       (re),
    .pad0_btn (pad0_btn),
    .pad1_btn (pad1_btn),
    .dout     (dout),
    .dout_en  (dout_en)
  );

  task automatic cpu_read(input logic [15:0] a,
                          output exp_t got);
    @(negedge clk);
    addr = a; re = 1'b1; we = 1'b0;
    #1;
    got.en = dout_en;
    got.d  = dout;
    @(posedge clk);
    #1;
    re = 1'b0; addr = 16'h0000;
  endtask

  task automatic cpu_write(input logic [15:0] a,
                           input logic [7:0] v);
    @(negedge clk);
    addr = a; din = v; we = 1'b1; re = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0; addr = 16'h0000; din = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic latch_pads();
    cpu_write(JOY0_ADDR_DEF, 8'h01);
    idle(2);
    cpu_write(JOY0_ADDR_DEF, 8'h00);
  endtask

  task automatic test_reset();
    exp_t got, e;
    pad0_btn = 8'hFF;
    pad1_btn = 8'hFF;
    @(negedge clk);
    reset_n = 1'b0;
    idle(3);
    @(negedge clk);
    sb.push_back('{en: 1'b0, d: 8'h00});
    got.en = dout_en; got.d = dout;
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b d=%h exp en=%b d=%h",
               got.en, got.d, e.en, e.d);
    end
    reset_n = 1'b1;
    sb.push_back('{en: 1'b1, d: 8'h40});
    cpu_read(JOY0_ADDR_DEF, got);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_first_read: got en=%b d=%h exp en=%b d=%h",
               got.en, got.d, e.en, e.d);
    end
  endtask

  task automatic test_latch_exhaust();
    exp_t got, e;
    logic [7:0] v;
    v = 8'hA5;
    pad0_btn = v;
    idle(4);
    latch_pads();
    for (int i = 0; i < 10; i++)
      sb.push_back('{en: 1'b1,
                     d: {7'b0100000, (i < 8) ? v[i] : 1'b1}});
    for (int i = 0; i < 10; i++) begin
      cpu_read(JOY0_ADDR_DEF, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL latch_read%0d: got en=%b d=%h exp en=%b d=%h",
                 i, got.en, got.d, e.en, e.d);
      end
    end
  endtask

  task automatic test_strobe_high();
    exp_t got, e;
    cpu_write(JOY0_ADDR_DEF, 8'h01);
    pad0_btn = 8'h01;
    idle(4);
    repeat (3) sb.push_back('{en: 1'b1, d: 8'h41});
    for (int i = 0; i < 3; i++) begin
      cpu_read(JOY0_ADDR_DEF, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL strobe_hi_a%0d: got en=%b d=%h exp en=%b d=%h",
                 i, got.en, got.d, e.en, e.d);
      end
    end
    pad0_btn = 8'h00;
    idle(4);
    repeat (2) sb.push_back('{en: 1'b1, d: 8'h40});
    for (int i = 0; i < 2; i++) begin
      cpu_read(JOY0_ADDR_DEF, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL strobe_hi_b%0d: got en=%b d=%h exp en=%b d=%h",
                 i, got.en, got.d, e.en, e.d);
      end
    end
    cpu_write(JOY0_ADDR_DEF, 8'h00);
  endtask

  task automatic test_pad_independence();
    exp_t got, e;
    pad0_btn = 8'h0F;
    pad1_btn = 8'hF0;
    idle(4);
    latch_pads();
    repeat (4) sb.push_back('{en: 1'b1, d: 8'h40});
    sb.push_back('{en: 1'b1, d: 8'h41});
    for (int i = 0; i < 5; i++) begin
      cpu_read((i < 4) ? JOY1_ADDR_DEF : JOY0_ADDR_DEF, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL indep_read%0d: got en=%b d=%h exp en=%b d=%h",
                 i, got.en, got.d, e.en, e.d);
      end
    end
    cpu_write(JOY1_ADDR_DEF, 8'h01);
    pad0_btn = 8'h00;
    idle(4);
    sb.push_back('{en: 1'b0, d: 8'h00});
    cpu_read(16'h4018, got);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL unsel_read: got en=%b d=%h exp en=%b d=%h",
               got.en, got.d, e.en, e.d);
    end
    // 0F shifted once: bit1 = 1; a reload of 00 would give 0
    sb.push_back('{en: 1'b1, d: 8'h41});
    cpu_read(JOY0_ADDR_DEF, got);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL joy1_write_ignored: got en=%b d=%h exp en=%b d=%h",
               got.en, got.d, e.en, e.d);
    end
  endtask

  task automatic test_midshift_reset();
    exp_t got, e;
    pad0_btn = 8'hFF;
    idle(4);
    latch_pads();
    repeat (3) sb.push_back('{en: 1'b1, d: 8'h41});
    for (int i = 0; i < 3; i++) begin
      cpu_read(JOY0_ADDR_DEF, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL midrst_pre%0d: got en=%b d=%h exp en=%b d=%h",
                 i, got.en, got.d, e.en, e.d);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back('{en: 1'b1, d: 8'h40});
    cpu_read(JOY0_ADDR_DEF, got);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL midrst_post: got en=%b d=%h exp en=%b d=%h",
               got.en, got.d, e.en, e.d);
    end
  endtask

  task automatic test_collision();
    exp_t got, e;
    pad0_btn = 8'h02;
    idle(4);
    latch_pads();
    sb.push_back('{en: 1'b0, d: 8'h00});
    @(negedge clk);
    addr = JOY0_ADDR_DEF; din = 8'h00; we = 1'b1; re = 1'b1;
    #1;
    got.en = dout_en; got.d = dout;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; addr = 16'h0000;
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL collide_out: got en=%b d=%h exp en=%b d=%h",
               got.en, got.d, e.en, e.d);
    end
    sb.push_back('{en: 1'b1, d: 8'h40});
    sb.push_back('{en: 1'b1, d: 8'h41});
    for (int i = 0; i < 2; i++) begin
      cpu_read(JOY0_ADDR_DEF, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL collide_next%0d: got en=%b d=%h exp en=%b d=%h",
                 i, got.en, got.d, e.en, e.d);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    addr     = 16'h0000;
    din      = 8'h00;
    we       = 1'b0;
    re       = 1'b0;
    pad0_btn = 8'h00;
    pad1_btn = 8'h00;
    test_reset();
    test_latch_exhaust();
    test_strobe_high();
    test_pad_independence();
    test_midshift_reset();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/joypad_io.md
Name: joypad_io

Overview:
- Memory-mapped controller-port responder on the 6502 CPU bus. Serves the CPU's accesses to $4016/$4017 beside `mem`.
- Latches two 8-button controller states when software strobes $4016 bit 0.
- Returns one button bit per CPU read of $4016 (pad 0) or $4017 (pad 1), shifting serially.
- Top level muxes `dout` onto D when `dout_en` is high; `mem` is deselected for those addresses.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (16): CPU address bus width.
- REG_WIDTH, `REG_WIDTH (8): data bus width.
- JOY0_ADDR, 16'h4016: pad 0 read address and strobe write address.
- JOY1_ADDR, 16'h4017: pad 1 read address. Writes to this address are ignored.
- OPEN_BUS, 8'h40: value driven on read-data bits [7:1].
- SYNC_STAGES, 2: synchronizer depth on button inputs (minimum 1).

Ports:
- clk  in  1  block clock; same edge as `mem`.
- reset_n  in  1  synchronous active-low reset.
- addr  in  ADDR_WIDTH  CPU address (A).
- din  in  REG_WIDTH  CPU write data.
- we  in  1  one-cycle write qualifier (!R_W_n & valid).
- re  in  1  one-cycle read qualifier (R_W_n & valid); pulses exactly once per CPU read.
- pad0_btn  in  8  live pad 0 buttons, active high. Bit 0..7 = A, B, Select, Start, Up, Down, Left, Right.
- pad1_btn  in  8  live pad 1 buttons, same bit order.
- dout  out  REG_WIDTH  read data.
- dout_en  out  1  high when this block owns D.

Behaviour:
- Reset (clk edge with reset_n=0): strobe=0, both shift regs=8'h00, synchronizer flops=0. The combinational outputs then read dout_en=0, dout=8'h00.
- Synchronizer: each pad's btn passes through SYNC_STAGES flops. Buttons are seen by the latch SYNC_STAGES cycles after they change.
- Select:
  - sel0 = (addr==JOY0_ADDR).
  - sel1 = (addr==JOY1_ADDR).
  - dout_en = re & ~we & (sel0|sel1).
- Read data (combinational, zero latency):
  - dout = {OPEN_BUS[7:1], sr_x[0]} while dout_en.
  - dout = 8'h00 otherwise.
- Strobe write: we & sel0 → strobe <= din[0] on the next edge. din[7:1] is ignored.
- Strobe high: every cycle, sr0 <= synced pad0 and sr1 <= synced pad1. Reads return the current A bit and do not shift.
- Strobe low: shift regs hold. Each read edge (re & sel_x & ~strobe) does sr_x <= {1'b1, sr_x[7:1]}. Only the addressed pad shifts.
- Exhaustion: after 8 reads, further reads return 1 indefinitely (fill bit), with no wrap-around.
- Falling strobe: the register contents from the last strobe-high cycle are frozen. No extra cycle is inserted.
- we & re in the same cycle: the write wins, the read is ignored (dout_en=0, no shift).
- Write to JOY1_ADDR: no effect. A read of an unselected address has no side effect.
- Reset mid-sequence: state returns to the reset values. The first read after reset with strobe=0 returns bit 0 = 0.

Decomposition:
- pkg.v adds:
  - `JOY0_ADDR and `JOY1_ADDR.
  - `JOY_OPEN_BUS.
  - A `BTN_A..`BTN_RIGHT bit-index list.
  - A joypad_btn_t 8-bit typedef, shared with the bench.
- Sub-module joypad_shift, instantiated twice. It contains the synchronizer, the 8-bit shift reg, and load/shift control. It takes strobe, shift_en, btn and outputs bit0.
- The top holds the strobe flop, address decode and output mux.

Test Plan:
- Reset: reset_n=0 for 3 clks with pad0=8'hFF → dout_en=0, dout=00. After release, one read of $4016 → dout=8'h40.
- Basic latch: pad0=8'hA5; write 01 then 00 to $4016; 8 reads of $4016 → bit 0 sequence 1,0,1,0,0,1,0,1, each dout=8'h41 or 8'h40.
- Exhaustion: continue the previous test with a 9th and 10th read → dout=8'h41 both.
- Strobe held high: write 01 to $4016; pad0=8'h01 then 8'h00 → reads return 8'h41 then 8'h40 (after sync delay), with no shifting across repeated reads.
- Pad independence: pad0=8'h0F, pad1=8'hF0; strobe; 4 reads of $4017 then 1 read of $4016 → pad 1 returns 0,0,0,0, then pad 0 returns 1. Also write 01 to $4017 → no strobe change.
- Mid-shift reset and collision:
  - After 3 reads, assert reset_n=0 for 1 clk → next read returns 8'h40.
  - A cycle with we&re at $4016 → dout_en=0 and no shift occurs (verified by the next read value).
